// File: rtl/product_term_configurator_pkg.sv
// Shared types and constants for the product-term configuration writer.
`timescale 1ns/1ps
package product_term_configurator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT_IN  = 2'd1,
    COMMIT    = 2'd2,
    SHIFT_OUT = 2'd3
  } state_e;

  localparam logic COMMAND_WRITE = 1'b1;
  localparam logic COMMAND_READ  = 1'b0;

endpackage

// File: rtl/configuration_shift_register.sv
// Row-wide staging register: parallel load for readback, indexed bit write
// for serial load, shift-right for serial readback with bit 0 as output.
`timescale 1ns/1ps
module configuration_shift_register #(
  parameter int width       = 88,
  parameter int index_width = (width > 1) ? $clog2(width) : 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   load_enable,
  input  logic [width-1:0]       load_data,
  input  logic                   write_enable,
  input  logic [index_width-1:0] write_index,
  input  logic                   write_bit,
  input  logic                   shift_enable,
  output logic                   serial_bit,
  output logic [width-1:0]       data
);

  // Load has priority over an indexed write, which has priority over a shift.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
    end else if (load_enable) begin
      data <= load_data;
    end else if (write_enable) begin
      data[write_index] <= write_bit;
    end else if (shift_enable) begin
      data <= data >> 1;
    end
  end

  assign serial_bit = data[0];

endmodule

// File: rtl/product_term_configurator.sv
// Holds the product-term configuration rows and loads / reads them back
// bit-serially (LSB first) under a command and valid/ready handshake.
`timescale 1ns/1ps
module product_term_configurator
  import product_term_configurator_pkg::*;
#(
  parameter int input_signal_count = 88,
  parameter int product_term_count = 5,
  parameter int address_width      = $clog2(product_term_count)
) (
  input  logic                                         clock,
  input  logic                                         reset_n,
  input  logic                                         command_valid,
  output logic                                         command_ready,
  input  logic                                         command_write,
  input  logic [address_width-1:0]                     command_address,
  input  logic                                         abort,
  input  logic                                         serial_in_data,
  input  logic                                         serial_in_valid,
  output logic                                         serial_in_ready,
  output logic                                         serial_out_data,
  output logic                                         serial_out_valid,
  input  logic                                         serial_out_ready,
  output logic                                         done,
  output logic                                         error,
  output logic [product_term_count*input_signal_count-1:0] configuration
);

  localparam int counter_width = (input_signal_count > 1) ? $clog2(input_signal_count) : 1;
  localparam logic [counter_width-1:0] last_bit  = counter_width'(input_signal_count - 1);
  localparam logic [address_width:0]   row_limit = (address_width + 1)'(product_term_count);

  state_e                          state;
  logic [counter_width-1:0]        bit_count;
  logic [address_width-1:0]        row_address;
  logic [input_signal_count-1:0]   rows [product_term_count];
  logic [input_signal_count-1:0]   selected_row;
  logic [input_signal_count-1:0]   shift_data;
  logic                            command_fire;
  logic                            address_bad;
  logic                            load_fire;
  logic                            in_fire;
  logic                            out_fire;
  logic                            commit_fire;

  assign command_fire = command_valid && (state == IDLE);
  assign address_bad  = ({1'b0, command_address} >= row_limit);
  assign load_fire    = command_fire && !address_bad && (command_write == COMMAND_READ);
  // Abort wins over a bit handshake or a commit in the same cycle.
  assign in_fire      = (state == SHIFT_IN) && serial_in_valid && !abort;
  assign out_fire     = (state == SHIFT_OUT) && serial_out_ready && !abort;
  assign commit_fire  = (state == COMMIT) && !abort;

  assign command_ready    = (state == IDLE);
  assign serial_in_ready  = (state == SHIFT_IN);
  assign serial_out_valid = (state == SHIFT_OUT);

  // Row mux for readback loads; an out-of-range address selects nothing.
  always_comb begin
    selected_row = '1;
    for (int r = 0; r < product_term_count; r++) begin
      if (command_address == address_width'(r)) selected_row = rows[r];
    end
  end

  configuration_shift_register #(
    .width       (input_signal_count),
    .index_width (counter_width)
  ) u_shift_register (
    .clock        (clock),
    .reset_n      (reset_n),
    .load_enable  (load_fire),
    .load_data    (selected_row),
    .write_enable (in_fire),
    .write_index  (bit_count),
    .write_bit    (serial_in_data),
    .shift_enable (out_fire),
    .serial_bit   (serial_out_data),
    .data         (shift_data)
  );

  // Control FSM: command decode, bit counting, done/error pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_count   <= '0;
      row_address <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (command_fire) begin
            if (address_bad) begin
              error <= 1'b1;
            end else begin
              row_address <= command_address;
              bit_count   <= '0;
              state       <= (command_write == COMMAND_WRITE) ? SHIFT_IN : SHIFT_OUT;
            end
          end
        end
        SHIFT_IN: begin
          if (abort) begin
            state <= IDLE;
          end else if (in_fire) begin
            if (bit_count == last_bit) state <= COMMIT;
            else                       bit_count <= bit_count + 1'b1;
          end
        end
        COMMIT: begin
          state <= IDLE;
          done  <= !abort;
        end
        SHIFT_OUT: begin
          if (abort) begin
            state <= IDLE;
          end else if (out_fire) begin
            if (bit_count == last_bit) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              bit_count <= bit_count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Row storage: erased (all ones) on reset, only the addressed row commits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < product_term_count; r++) rows[r] <= '1;
    end else if (commit_fire) begin
      for (int r = 0; r < product_term_count; r++) begin
        if (row_address == address_width'(r)) rows[r] <= shift_data;
      end
    end
  end

  for (genvar r = 0; r < product_term_count; r++) begin : g_configuration
    assign configuration[r*input_signal_count +: input_signal_count] = rows[r];
  end

endmodule

// File: tb/tb_product_term_configurator.sv
// Directed bench for product_term_configurator: write, stalled readback,
// invalid address, abort, bit-0 storage and mid-operation reset.
`timescale 1ns/1ps
module tb_product_term_configurator;

  localparam int W  = 88;
  localparam int N  = 5;
  localparam int AW = 3;
  localparam logic [W-1:0] PATTERN = 88'h0F0F0F0F0F0F0F0F0F0F0F;
  localparam logic [W-1:0] ONES    = {W{1'b1}};

  logic           clock = 1'b0;
  logic           reset_n;
  logic           command_valid;
  logic           command_ready;
  logic           command_write;
  logic [AW-1:0]  command_address;
  logic           abort;
  logic           serial_in_data;
  logic           serial_in_valid;
  logic           serial_in_ready;
  logic           serial_out_data;
  logic           serial_out_valid;
  logic           serial_out_ready;
  logic           done;
  logic           error;
  logic [N*W-1:0] configuration;

  int compared   = 0;
  int mismatched = 0;
  logic [N*W-1:0] exp_config;

  product_term_configurator #(
    .input_signal_count (W),
    .product_term_count (N),
    .address_width      (AW)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .command_valid    (command_valid),
    .command_ready    (command_ready),
    .command_write    (command_write),
    .command_address  (command_address),
    .abort            (abort),
    .serial_in_data   (serial_in_data),
    .serial_in_valid  (serial_in_valid),
    .serial_in_ready  (serial_in_ready),
    .serial_out_data  (serial_out_data),
    .serial_out_valid (serial_out_valid),
    .serial_out_ready (serial_out_ready),
    .done             (done),
    .error            (error),
    .configuration    (configuration)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_command(input logic wr, input logic [AW-1:0] addr);
    command_valid   = 1'b1;
    command_write   = wr;
    command_address = addr;
    tick();
    command_valid   = 1'b0;
  endtask

  task automatic shift_in_bits(input logic [W-1:0] value, input int count);
    for (int i = 0; i < count; i++) begin
      serial_in_data  = value[i];
      serial_in_valid = 1'b1;
      tick();
    end
    serial_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    compared++;
    if (configuration !== {N{ONES}}) begin
      mismatched++; $display("FAIL reset_configuration: got %h required all ones", configuration);
    end
    compared++;
    if (command_ready !== 1'b1) begin
      mismatched++; $display("FAIL reset_command_ready: got %b required 1", command_ready);
    end
    compared++;
    if ({serial_in_ready, serial_out_valid, done, error, serial_out_data} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got in_rdy=%b out_vld=%b done=%b err=%b out_data=%b required all 0",
               serial_in_ready, serial_out_valid, done, error, serial_out_data);
    end
  endtask

  task automatic test_write();
    send_command(1'b1, 3'd2);
    compared++;
    if (serial_in_ready !== 1'b1 || command_ready !== 1'b0) begin
      mismatched++; $display("FAIL write_enter_shift_in: got in_rdy=%b cmd_rdy=%b required 1/0", serial_in_ready, command_ready);
    end
    shift_in_bits(PATTERN, W);
    // One COMMIT cycle: nothing visible yet.
    compared++;
    if (command_ready !== 1'b0 || serial_in_ready !== 1'b0 || done !== 1'b0 || configuration !== exp_config) begin
      mismatched++; $display("FAIL write_commit_cycle: got cmd_rdy=%b in_rdy=%b done=%b required 0/0/0, config unchanged", command_ready, serial_in_ready, done);
    end
    tick();
    exp_config[2*W +: W] = PATTERN;
    compared++;
    if (done !== 1'b1 || command_ready !== 1'b1) begin
      mismatched++; $display("FAIL write_done: got done=%b cmd_rdy=%b required 1/1", done, command_ready);
    end
    compared++;
    if (configuration !== exp_config) begin
      mismatched++; $display("FAIL write_configuration: got %h required %h", configuration, exp_config);
    end
    tick();
    compared++;
    if (done !== 1'b0) begin
      mismatched++; $display("FAIL write_done_single_pulse: got %b required 0", done);
    end
  endtask

  task automatic test_readback_stalls();
    logic [W-1:0] rx;
    int got;
    int dones;
    rx = '0; got = 0; dones = 0;
    send_command(1'b0, 3'd2);
    compared++;
    if (serial_out_valid !== 1'b1 || serial_in_ready !== 1'b0) begin
      mismatched++; $display("FAIL read_enter_shift_out: got out_vld=%b in_rdy=%b required 1/0", serial_out_valid, serial_in_ready);
    end
    for (int c = 0; c < 400 && got < W; c++) begin
      serial_out_ready = (c % 2 == 1);
      if (serial_out_valid && serial_out_ready) begin
        rx[got] = serial_out_data;
        got++;
      end
      tick();
      if (done) dones++;
    end
    serial_out_ready = 1'b0;
    compared++;
    if (got != W) begin
      mismatched++; $display("FAIL read_bit_count: got %0d bits required %0d (cycle budget expired)", got, W);
    end
    compared++;
    if (rx !== PATTERN) begin
      mismatched++; $display("FAIL read_data: got %h required %h", rx, PATTERN);
    end
    compared++;
    if (done !== 1'b1 || command_ready !== 1'b1) begin
      mismatched++; $display("FAIL read_done_latency: got done=%b cmd_rdy=%b required 1/1", done, command_ready);
    end
    repeat (3) begin
      tick();
      if (done) dones++;
    end
    compared++;
    if (dones != 1) begin
      mismatched++; $display("FAIL read_done_count: got %0d pulses required 1", dones);
    end
    compared++;
    if (configuration !== exp_config) begin
      mismatched++; $display("FAIL read_config_untouched: got %h required %h", configuration, exp_config);
    end
  endtask

  task automatic test_invalid_address();
    send_command(1'b1, 3'd5);
    compared++;
    if (error !== 1'b1 || done !== 1'b0) begin
      mismatched++; $display("FAIL invalid_error_pulse: got error=%b done=%b required 1/0", error, done);
    end
    compared++;
    if (command_ready !== 1'b1 || serial_in_ready !== 1'b0 || serial_out_valid !== 1'b0) begin
      mismatched++; $display("FAIL invalid_stays_idle: got cmd_rdy=%b in_rdy=%b out_vld=%b required 1/0/0", command_ready, serial_in_ready, serial_out_valid);
    end
    tick();
    compared++;
    if (error !== 1'b0) begin
      mismatched++; $display("FAIL invalid_error_width: got %b required 0", error);
    end
    compared++;
    if (configuration !== exp_config) begin
      mismatched++; $display("FAIL invalid_config_unchanged: got %h required %h", configuration, exp_config);
    end
  endtask

  task automatic test_abort();
    int dones;
    dones = 0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    compared++;
    if (command_ready !== 1'b1 || error !== 1'b0 || done !== 1'b0) begin
      mismatched++; $display("FAIL abort_idle_no_effect: got cmd_rdy=%b err=%b done=%b required 1/0/0", command_ready, error, done);
    end
    send_command(1'b1, 3'd3);
    shift_in_bits({W{1'b0}}, 40);
    abort           = 1'b1;
    serial_in_valid = 1'b1;
    serial_in_data  = 1'b0;
    tick();
    abort           = 1'b0;
    serial_in_valid = 1'b0;
    compared++;
    if (command_ready !== 1'b1 || serial_in_ready !== 1'b0) begin
      mismatched++; $display("FAIL abort_to_idle: got cmd_rdy=%b in_rdy=%b required 1/0", command_ready, serial_in_ready);
    end
    if (done) dones++;
    repeat (3) begin
      tick();
      if (done) dones++;
    end
    compared++;
    if (dones != 0) begin
      mismatched++; $display("FAIL abort_no_done: got %0d pulses required 0", dones);
    end
    compared++;
    if (configuration !== exp_config) begin
      mismatched++; $display("FAIL abort_row_unchanged: got %h required %h", configuration, exp_config);
    end
    send_command(1'b1, 3'd3);
    shift_in_bits(PATTERN, W);
    tick();
    exp_config[3*W +: W] = PATTERN;
    compared++;
    if (done !== 1'b1 || configuration !== exp_config) begin
      mismatched++; $display("FAIL abort_rewrite: got done=%b config=%h required 1 / %h", done, configuration, exp_config);
    end
  endtask

  task automatic test_bit0_storage();
    logic [W-1:0] rx;
    int got;
    rx = '1; got = 0;
    send_command(1'b1, 3'd0);
    shift_in_bits({W{1'b0}}, W);
    tick();
    exp_config[0 +: W] = '0;
    compared++;
    if (done !== 1'b1 || configuration !== exp_config) begin
      mismatched++; $display("FAIL bit0_write: got done=%b config=%h required 1 / %h", done, configuration, exp_config);
    end
    compared++;
    if (configuration[0] !== 1'b0) begin
      mismatched++; $display("FAIL bit0_stored: got %b required 0", configuration[0]);
    end
    send_command(1'b0, 3'd0);
    serial_out_ready = 1'b1;
    for (int c = 0; c < 200 && got < W; c++) begin
      if (serial_out_valid) begin
        rx[got] = serial_out_data;
        got++;
      end
      tick();
    end
    serial_out_ready = 1'b0;
    compared++;
    if (got != W || rx !== {W{1'b0}}) begin
      mismatched++; $display("FAIL bit0_readback: got %0d bits value %h required %0d bits of 0", got, rx, W);
    end
    compared++;
    if (done !== 1'b1) begin
      mismatched++; $display("FAIL bit0_read_done: got %b required 1", done);
    end
  endtask

  task automatic test_mid_reset();
    send_command(1'b1, 3'd1);
    shift_in_bits(PATTERN, 10);
    serial_in_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    compared++;
    if (configuration !== {N{ONES}}) begin
      mismatched++; $display("FAIL mid_reset_configuration: got %h required all ones", configuration);
    end
    compared++;
    if (command_ready !== 1'b1 || serial_in_ready !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      mismatched++; $display("FAIL mid_reset_control: got cmd_rdy=%b in_rdy=%b done=%b err=%b required 1/0/0/0", command_ready, serial_in_ready, done, error);
    end
    serial_in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_config = {N{ONES}};
    tick();
    compared++;
    if (command_ready !== 1'b1 || configuration !== exp_config) begin
      mismatched++; $display("FAIL mid_reset_release: got cmd_rdy=%b config=%h required 1 / all ones", command_ready, configuration);
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    command_valid    = 1'b0;
    command_write    = 1'b0;
    command_address  = '0;
    abort            = 1'b0;
    serial_in_data   = 1'b0;
    serial_in_valid  = 1'b0;
    serial_out_ready = 1'b0;
    exp_config       = {N{ONES}};
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset_n = 1'b1;
    tick();
    test_write();
    test_readback_stalls();
    test_invalid_address();
    test_abort();
    test_bit0_storage();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
